// File: rtl/sg_desc_fetch.sv
// Scatter-gather descriptor fetch: walks a linked list of 32-byte descriptors over Avalon-MM and pushes packed words.
// Optional SG_DESC_FETCH_ALIGN_CHECK_EN: reject descriptor pointers that are not 32-byte aligned.
module sg_desc_fetch #(
  parameter int MAX_CHAIN = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [31:0]  head_ptr_i,
  input  logic         stop_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  output logic [15:0]  desc_count_o,
  output logic [31:0]  mm_address_o,
  output logic         mm_read_o,
  input  logic         mm_waitrequest_i,
  input  logic [31:0]  mm_readdata_i,
  input  logic         mm_readdatavalid_i,
  output logic         desc_fifo_wr_o,
  output logic [264:0] desc_fifo_wrdata_o,
  input  logic         desc_fifo_full_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SPACE, S_FETCH, S_CHECK, S_PUSH, S_DONE
  } state_t;

  localparam logic [16:0] LP_MAX = 17'(MAX_CHAIN);

  state_t         r_state;
  logic           r_stop;
  logic           r_busy;
  logic           r_done;
  logic           r_error;
  logic           r_wr;
  logic           r_mm_read;
  logic [31:0]    r_addr;
  logic [31:0]    r_ptr;
  logic [15:0]    r_desc_count;
  logic [3:0]     r_issue_cnt;
  logic [3:0]     r_rx_cnt;
  logic [255:0]   r_words;
  logic [264:0]   r_wrdata;

  logic           w_stop;
  logic           w_acc;
  logic           w_rdv;
  logic [3:0]     w_issue_nxt;
  logic [3:0]     w_rx_nxt;
  logic           w_read_nxt;
  logic [255:0]   w_words;
  logic [16:0]    w_count_inc;

  assign w_stop      = r_stop | stop_i;
  assign w_count_inc = {1'b0, r_desc_count} + 17'd1;

  // Next-cycle view of the fetch counters; the request is held while the slave stalls.
  always_comb begin
    w_acc       = (r_state == S_FETCH) && r_mm_read && !mm_waitrequest_i;
    w_rdv       = (r_state == S_FETCH) && mm_readdatavalid_i && (r_rx_cnt < 4'd8);
    w_issue_nxt = r_issue_cnt + {3'd0, w_acc};
    w_rx_nxt    = r_rx_cnt + {3'd0, w_rdv};
    w_read_nxt  = w_acc ? ((w_issue_nxt < 4'd8) && !w_stop) : r_mm_read;
    w_words     = r_words;
    if (w_rdv)
      w_words[{r_rx_cnt[2:0], 5'd0} +: 32] = mm_readdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_stop       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_wr         <= 1'b0;
      r_mm_read    <= 1'b0;
      r_addr       <= 32'd0;
      r_ptr        <= 32'd0;
      r_desc_count <= 16'd0;
      r_issue_cnt  <= 4'd0;
      r_rx_cnt     <= 4'd0;
      r_words      <= 256'd0;
      r_wrdata     <= 265'd0;
    end else begin
      r_done <= 1'b0;
      r_wr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stop <= 1'b0;
          if (start_i) begin
            r_ptr        <= head_ptr_i;
            r_desc_count <= 16'd0;
            r_error      <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT_SPACE;
          end
        end
        S_WAIT_SPACE: begin
          r_stop      <= w_stop;
          r_issue_cnt <= 4'd0;
          r_rx_cnt    <= 4'd0;
          if (w_stop) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
`ifdef SG_DESC_FETCH_ALIGN_CHECK_EN
          else if (r_ptr[4:0] != 5'd0) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
`endif
          else if (!desc_fifo_full_i) begin
            r_mm_read <= 1'b1;
            r_addr    <= r_ptr;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_stop      <= w_stop;
          r_issue_cnt <= w_issue_nxt;
          r_rx_cnt    <= w_rx_nxt;
          r_mm_read   <= w_read_nxt;
          r_words     <= w_words;
          if (w_acc)
            r_addr <= r_ptr + {26'd0, w_issue_nxt, 2'b00};
          // A stopped fetch leaves only once every issued read has returned.
          if (w_stop && !w_read_nxt && (w_rx_nxt == w_issue_nxt)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_rx_nxt == 4'd8) begin
            r_wrdata <= {w_words[255:248], (w_words[159:128] == 32'd0), w_words};
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_stop <= w_stop;
          if (!r_wrdata[255]) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wr    <= 1'b1;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          r_stop       <= w_stop;
          r_desc_count <= r_desc_count + 16'd1;
          if (r_wrdata[256]) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_count_inc == LP_MAX) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_stop) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ptr   <= r_wrdata[159:128];
            r_state <= S_WAIT_SPACE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o             = r_busy;
  assign done_o             = r_done;
  assign error_o            = r_error;
  assign desc_count_o       = r_desc_count;
  assign mm_address_o       = r_addr;
  assign mm_read_o          = r_mm_read;
  assign desc_fifo_wr_o     = r_wr;
  assign desc_fifo_wrdata_o = r_wrdata;

endmodule

// File: tb/tb_sg_desc_fetch.sv
// Directed plus randomized bench for sg_desc_fetch with an Avalon-MM memory slave and a list-walking reference model.
module tb_sg_desc_fetch;

  localparam int TB_MAX = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic [31:0]  head_ptr_i = 32'd0;
  logic         stop_i = 1'b0;
  logic         busy_o, done_o, error_o;
  logic [15:0]  desc_count_o;
  logic [31:0]  mm_address_o;
  logic         mm_read_o;
  logic         mm_waitrequest_i = 1'b0;
  logic [31:0]  mm_readdata_i = 32'd0;
  logic         mm_readdatavalid_i = 1'b0;
  logic         desc_fifo_wr_o;
  logic [264:0] desc_fifo_wrdata_o;
  logic         desc_fifo_full_i = 1'b0;

  sg_desc_fetch #(.MAX_CHAIN(TB_MAX)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .head_ptr_i(head_ptr_i), .stop_i(stop_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .desc_count_o(desc_count_o),
    .mm_address_o(mm_address_o), .mm_read_o(mm_read_o), .mm_waitrequest_i(mm_waitrequest_i),
    .mm_readdata_i(mm_readdata_i), .mm_readdatavalid_i(mm_readdatavalid_i),
    .desc_fifo_wr_o(desc_fifo_wr_o), .desc_fifo_wrdata_o(desc_fifo_wrdata_o),
    .desc_fifo_full_i(desc_fifo_full_i)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]  mem [logic [31:0]];
  logic [264:0] exp_push [$];
  logic [31:0]  exp_addr [$];
  int           exp_npush, exp_err, exp_cnt;

  logic [31:0]  issued [$];
  logic [31:0]  pend_a [$];
  int           pend_due [$];
  int cyc = 0, last_due = 0, acc_cnt = 0, done_cnt = 0, push_cnt = 0;
  int rdv_cnt = 0, last8_cyc = 0, rd_while_full = 0;
  int g_lat = 1, g_wmode = 0, g_stop_at = 0;
  bit g_force_stop = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [264:0] obs, input logic [264:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  task automatic put_desc(input logic [31:0] a, input logic [31:0] nxt,
                          input logic [15:0] bc, input logic [7:0] id);
    for (int i = 0; i < 8; i++) mem[a + 32'(4 * i)] = $urandom;
    mem[a + 32'd16] = nxt;
    mem[a + 32'd24] = {16'($urandom), bc};
    mem[a + 32'd28] = {id, 24'($urandom)};
  endtask

  // Walk the list the way software sees it and list the expected reads and pushes.
  task automatic build_model(input logic [31:0] head);
    logic [31:0]  p;
    logic [31:0]  w [8];
    logic [255:0] v;
    exp_push.delete(); exp_addr.delete();
    exp_err = 0; exp_cnt = 0; p = head;
    for (int d = 0; d <= TB_MAX; d++) begin
`ifdef SG_DESC_FETCH_ALIGN_CHECK_EN
      if (p[4:0] != 5'd0) begin exp_err = 1; break; end
`endif
      for (int i = 0; i < 8; i++) begin
        exp_addr.push_back(p + 32'(4 * i));
        w[i] = rd_word(p + 32'(4 * i));
        v[32*i +: 32] = w[i];
      end
      if (!w[7][31]) begin exp_err = 1; break; end
      exp_push.push_back({w[7][31:24], (w[4] == 32'd0), v});
      exp_cnt++;
      if (w[4] == 32'd0) break;
      if (exp_cnt == TB_MAX) begin exp_err = 1; break; end
      p = w[4];
    end
    exp_npush = exp_push.size();
  endtask

  // Memory slave and output monitor, acting just after each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (desc_fifo_wr_o) begin
        push_cnt++;
        if (exp_push.size() > 0) chkw("push_data", desc_fifo_wrdata_o, exp_push.pop_front());
        chk("push_latency", cyc - last8_cyc, 2);
      end
      if (done_o) done_cnt++;
      if (mm_read_o && desc_fifo_full_i) rd_while_full++;
      if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
        void'(pend_due.pop_front());
        mm_readdata_i = rd_word(pend_a.pop_front());
        mm_readdatavalid_i = 1'b1;
        rdv_cnt++;
        if (rdv_cnt % 8 == 0) last8_cyc = cyc;
      end else begin
        mm_readdatavalid_i = 1'b0;
        mm_readdata_i = $urandom;
      end
      mm_waitrequest_i = (g_wmode != 0) ? 1'($urandom % 2) : 1'b0;
      stop_i = g_force_stop;
      g_force_stop = 1'b0;
      if (mm_read_o && !mm_waitrequest_i && !reset) begin
        int due;
        issued.push_back(mm_address_o);
        due = cyc + g_lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_a.push_back(mm_address_o);
        pend_due.push_back(due);
        acc_cnt++;
        if (g_stop_at != 0 && acc_cnt == g_stop_at) stop_i = 1'b1;
      end
    end
  end

  task automatic run_chain(input string nm, input logic [31:0] head, input int lat, input int wm,
                           input int stop_at, input int full_cyc, input bit with_stop, input bit tchk);
    issued.delete();
    done_cnt = 0; push_cnt = 0; acc_cnt = 0; rdv_cnt = 0; rd_while_full = 0;
    g_lat = lat; g_wmode = wm; g_stop_at = stop_at;
    if (full_cyc > 0) desc_fifo_full_i = 1'b1;
    @(negedge clk);
    start_i = 1'b1; head_ptr_i = head;
    if (with_stop) g_force_stop = 1'b1;
    @(negedge clk);
    start_i = 1'b0; head_ptr_i = $urandom;
    if (tchk) begin
      chk({nm, "_busy_rise"}, int'(busy_o), 1);
      chk({nm, "_read_not_yet"}, int'(mm_read_o), 0);
      @(negedge clk);
      chk({nm, "_first_read"}, int'(mm_read_o), 1);
      chk({nm, "_first_addr"}, int'(mm_address_o), int'(head));
    end
    if (full_cyc > 0) begin
      repeat (full_cyc) @(negedge clk);
      chk({nm, "_busy_while_full"}, int'(busy_o), 1);
      chk({nm, "_reads_while_full"}, issued.size() + rd_while_full, 0);
      desc_fifo_full_i = 1'b0;
    end
    for (int c = 0; c < 5000; c++) begin
      if (done_cnt > 0 && !busy_o) break;
      @(negedge clk);
    end
    chk({nm, "_finished"}, int'(done_cnt > 0 && !busy_o), 1);
    repeat (12) @(negedge clk);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_push_count"}, push_cnt, exp_npush);
    chk({nm, "_unmatched_pushes"}, exp_push.size(), 0);
    chk({nm, "_read_count"}, issued.size(), exp_addr.size());
    for (int i = 0; i < issued.size() && i < exp_addr.size(); i++)
      chk({nm, "_read_addr"}, int'(issued[i]), int'(exp_addr[i]));
    chk({nm, "_error"}, int'(error_o), exp_err);
    chk({nm, "_desc_count"}, int'(desc_count_o), exp_cnt);
    chk({nm, "_busy_idle"}, int'(busy_o), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_error", int'(error_o), 0);
    chk("rst_read", int'(mm_read_o), 0);
    chk("rst_wr", int'(desc_fifo_wr_o), 0);
    chk("rst_addr", int'(mm_address_o), 0);
    chk("rst_count", int'(desc_count_o), 0);
    chkw("rst_wrdata", desc_fifo_wrdata_o, 265'd0);
    reset = 1'b0;
    @(negedge clk);

    // single owned descriptor ending the chain
    mem.delete();
    put_desc(32'h1000, 32'h0, 16'h0040, 8'h85);
    build_model(32'h1000);
    run_chain("single", 32'h1000, 1, 0, 0, 0, 1'b0, 1'b1);

    // three descriptors with stalls and slow returns
    mem.delete();
    put_desc(32'h1000, 32'h2000, 16'h0100, 8'h81);
    put_desc(32'h2000, 32'h3000, 16'h0200, 8'h92);
    put_desc(32'h3000, 32'h0, 16'h0300, 8'hA3);
    build_model(32'h1000);
    run_chain("chain3", 32'h1000, 3, 1, 0, 0, 1'b0, 1'b0);

    // descriptor FIFO full for 20 cycles before the fetch may begin
    build_model(32'h3000);
    run_chain("full", 32'h3000, 2, 0, 0, 20, 1'b0, 1'b0);

    // second descriptor not owned by hardware
    mem.delete();
    put_desc(32'h1000, 32'h2000, 16'h0011, 8'h81);
    put_desc(32'h2000, 32'h3000, 16'h0022, 8'h12);
    put_desc(32'h3000, 32'h0, 16'h0033, 8'h83);
    build_model(32'h1000);
    run_chain("not_owned", 32'h1000, 2, 1, 0, 0, 1'b0, 1'b0);

    // stop with four reads issued: the rest are never issued and nothing is pushed
    mem.delete();
    put_desc(32'h1000, 32'h0, 16'h0044, 8'h84);
    exp_push.delete(); exp_addr.delete();
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'h1000 + 32'(4 * i));
    exp_npush = 0; exp_err = 0; exp_cnt = 0;
    run_chain("stop_fetch", 32'h1000, 2, 0, 4, 0, 1'b0, 1'b0);

    // unaligned head pointer
    mem.delete();
    put_desc(32'h1000, 32'h0, 16'h0055, 8'h85);
    mem[32'h1014] = 32'h0;
    build_model(32'h1004);
    run_chain("unaligned", 32'h1004, 1, 0, 0, 0, 1'b0, 1'b0);

    // chain longer than the chain limit
    mem.delete();
    for (int i = 0; i < 6; i++)
      put_desc(32'h8000 + 32'(i * 32'h100), (i == 5) ? 32'h0 : 32'h8000 + 32'((i + 1) * 32'h100),
               16'(i + 1), 8'h80 | 8'(i));
    build_model(32'h8000);
    run_chain("chain_limit", 32'h8000, 1, 1, 0, 0, 1'b0, 1'b0);

    // start and stop in the same idle cycle: the stop is ignored
    mem.delete();
    put_desc(32'h1000, 32'h2000, 16'h0066, 8'h86);
    put_desc(32'h2000, 32'h0, 16'h0077, 8'h87);
    build_model(32'h1000);
    run_chain("start_stop", 32'h1000, 1, 0, 0, 0, 1'b1, 1'b0);

    for (int k = 0; k < 5; k++) begin
      int n;
      logic [31:0] base;
      n = $urandom_range(1, 3);
      base = 32'h0001_0000 + 32'(k) * 32'h0001_0000;
      mem.delete();
      for (int i = 0; i < n; i++)
        put_desc(base + 32'(i * 32'h100), (i == n - 1) ? 32'h0 : base + 32'((i + 1) * 32'h100),
                 16'($urandom), {($urandom % 4 != 0), 7'($urandom)});
      build_model(base);
      run_chain("random", base, $urandom_range(1, 4), int'($urandom % 2), 0, 0, 1'b0, 1'b0);
    end

    // reset in the middle of a fetch; late read data must be ignored
    mem.delete();
    put_desc(32'h1000, 32'h0, 16'h0088, 8'h88);
    push_cnt = 0; done_cnt = 0; g_lat = 3; g_wmode = 0; g_stop_at = 0;
    @(negedge clk);
    start_i = 1'b1; head_ptr_i = 32'h1000;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_read", int'(mm_read_o), 0);
    chk("midrst_count", int'(desc_count_o), 0);
    repeat (20) @(negedge clk);
    chk("midrst_pushes", push_cnt, 0);
    chk("midrst_done", done_cnt, 0);
    chk("midrst_busy_late", int'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sg_desc_fetch.md
# sg_desc_fetch

Upstream descriptor-fetch stage of the scatter-gather DMA. Walks a linked list of 32-byte descriptors in memory through a 32-bit pipelined Avalon-MM read master. Each valid descriptor is packed into the 265-bit descriptor word and pushed into the descriptor processor's FIFO. Fetch runs only while that FIFO has space, and the chain stops on a null next pointer, a descriptor not owned by hardware, a software stop, or the chain-length limit.

## Interface
- MAX_CHAIN, 1024: maximum descriptors per chain; reaching it ends the chain with error.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start_i  in  1  one-cycle pulse; begins a chain at head_ptr_i; ignored unless idle
- head_ptr_i  in  32  byte address of first descriptor
- stop_i  in  1  pulse; abort after outstanding reads drain
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse at chain end
- error_o  out  1  sticky; cleared by the next accepted start_i
- desc_count_o  out  16  descriptors pushed in current or last chain
- mm_address_o  out  32  read word address (byte address)
- mm_read_o  out  1  read request
- mm_waitrequest_i  in  1  slave stall
- mm_readdata_i  in  32  read data
- mm_readdatavalid_i  in  1  read data strobe
- desc_fifo_wr_o  out  1  one-cycle push into descriptor processor FIFO
- desc_fifo_wrdata_o  out  265  packed descriptor
- desc_fifo_full_i  in  1  descriptor processor FIFO full

## Operation
- Memory descriptor is 8 words, w0..w7 at ptr+0..ptr+28:
  - w0: read address
  - w2: write address
  - w4: next pointer
  - w6[15:0]: byte count
  - w7[31:24]: id, where w7[31] is owned_by_hw
- Packed word layout:
  - [255:0] = {w7..w0}, so [31:0] = read address, [95:64] = write address, [159:128] = next pointer, [207:192] = byte count.
  - [256] = last flag (next pointer == 0).
  - [264:257] = w7[31:24].
- States:
  - IDLE: on start_i, go to WAIT_SPACE. Load ptr = head_ptr_i, clear desc_count_o, clear error_o.
  - WAIT_SPACE: go to FETCH when desc_fifo_full_i == 0. Clear issue_cnt and rx_cnt.
  - FETCH:
    - mm_read_o = (issue_cnt < 8); mm_address_o = ptr + 4*issue_cnt.
    - issue_cnt increments when mm_read_o & ~mm_waitrequest_i.
    - Each mm_readdatavalid_i stores the word at slot rx_cnt, then rx_cnt increments.
    - Go to CHECK when rx_cnt reaches 8.
  - CHECK:
    - w7[31] == 0: set error_o, go to DONE, no push.
    - Otherwise go to PUSH.
  - PUSH: assert desc_fifo_wr_o for one cycle and increment desc_count_o. Then:
    - If the last flag is set, go to DONE.
    - Else if desc_count_o + 1 == MAX_CHAIN, set error_o and go to DONE.
    - Otherwise ptr = next pointer, go to WAIT_SPACE.
  - DONE: pulse done_o, go to IDLE.
- stop_i latches a stop flag:
  - In WAIT_SPACE, go straight to DONE.
  - In FETCH, stop issuing, wait for rx_cnt == issue_cnt, then go to DONE with no push.
  - In CHECK or PUSH, the current descriptor completes, then go to DONE.
  - The stop flag clears in IDLE.
- mm_readdatavalid_i outside FETCH is ignored.
- desc_fifo_full_i is sampled only in WAIT_SPACE. This block is the FIFO's sole writer and pushes at most once per fetch, so the push cannot overflow.
- Address arithmetic is 32-bit modulo, with no wrap detection.

## Timing
- Reset values:
  - Outputs: busy_o, done_o, error_o, mm_read_o, desc_fifo_wr_o = 0; mm_address_o = 0; desc_count_o = 0; desc_fifo_wrdata_o = 0.
  - Internal: state = IDLE, stop flag = 0.
- start_i sampled at cycle T → WAIT_SPACE at T+1 → first mm_read_o at T+2 if the FIFO is not full.
- Up to 8 reads outstanding. Reads issue back-to-back; each read holds address and request while waitrequest is high.
- 8th readdatavalid at cycle R → CHECK at R+1 → desc_fifo_wr_o at R+2. desc_fifo_wrdata_o is stable from R+1 and holds until the next push.
- done_o occurs one cycle after the final PUSH or CHECK.
- Reset mid-chain returns to IDLE on the next edge with no push. Data arriving afterwards is ignored.
- start_i and stop_i asserted in the same IDLE cycle: start is accepted and the stop is ignored.

## Configuration
- SG_DESC_FETCH_ALIGN_CHECK_EN defined:
  - In WAIT_SPACE, ptr[4:0] != 0 sets error_o and goes to DONE, with no reads issued.
  - This applies to both the head pointer and next pointers.
- Undefined: ptr[4:0] is ignored and reads use the address as given.

## Test plan
- Single descriptor, owned bit set, next = 0, head = 0x1000 → eight reads at 0x1000..0x101C, one push, [256] = 1, done_o, desc_count_o = 1, error_o = 0.
- Three-descriptor chain 0x1000→0x2000→0x3000→0 with waitrequest toggling and readdatavalid delayed by 3 cycles → three pushes in order with correct ids and byte counts.
- desc_fifo_full_i held high for 20 cycles after start_i → no mm_read_o until it drops; fetch then proceeds normally.
- Second descriptor has w7[31] = 0 → exactly one push, error_o = 1, done_o pulses.
- stop_i during FETCH after 4 reads issued → remaining 4 not issued, 4 responses drained, no push, done_o pulses, busy_o falls.
- With the macro defined, head = 0x1004 → no reads, error_o = 1, done_o pulses. Without the macro, the same stimulus reads 0x1004..0x1020.
